// File: rtl/aes_key_sequencer.sv
// ---------------------------------------------------------------------------
// aes_key_sequencer
//
// Purpose:
//   Drives an external AES-256 key-schedule stage through all 15 rounds
//   (0..14), captures each round key into a local 15 x 128-bit buffer, and
//   then serves random-access reads of the stored round keys.
//
//   Handshake per round:
//     REQ  : key_en_o=1, round_count_o=cnt, wait for key_done_i pulse
//     CAPT : key_en_o=0, key_i (valid the cycle after key_done_i) is written
//            into buffer[cnt]; advance cnt or finish
//
// Ports:
//   clk_g          in   1    gated core clock, rising-edge
//   rst_n          in   1    asynchronous active-low reset
//   start_i        in   1    request a full key expansion (IDLE/READY only)
//   zeroize_i      in   1    (AES_KEYSEQ_ZEROIZE_EN only) wipe buffer, go IDLE
//   key_en_o       out  1    enable to the key-schedule stage
//   round_count_o  out  4    round index presented to the key-schedule stage
//   key_done_i     in   1    one-cycle done pulse from the key-schedule stage
//   key_i          in   128  round key, valid the cycle after key_done_i
//   busy_o         out  1    expansion in progress
//   ready_o        out  1    all 15 round keys stored
//   rd_en_i        in   1    round-key read request
//   rd_round_i     in   4    round-key read index
//   rk_o           out  128  read data (zero unless rk_valid_o)
//   rk_valid_o     out  1    read data valid strobe (one cycle)
//   rd_err_o       out  1    read error strobe (one cycle)
//
// Configuration:
//   AES_KEYSEQ_ZEROIZE_EN  adds the zeroize_i input. When undefined the
//                          buffer only changes through CAPT writes.
// ---------------------------------------------------------------------------
module aes_key_sequencer (
  input  logic         clk_g,
  input  logic         rst_n,
  input  logic         start_i,
`ifdef AES_KEYSEQ_ZEROIZE_EN
  input  logic         zeroize_i,
`endif
  output logic         key_en_o,
  output logic [3:0]   round_count_o,
  input  logic         key_done_i,
  input  logic [127:0] key_i,
  output logic         busy_o,
  output logic         ready_o,
  input  logic         rd_en_i,
  input  logic [3:0]   rd_round_i,
  output logic [127:0] rk_o,
  output logic         rk_valid_o,
  output logic         rd_err_o
);

  localparam logic [3:0] LAST_ROUND = 4'd14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    CAPT  = 2'd2,
    READY = 2'd3
  } state_t;

  state_t       state;
  logic [3:0]   cnt;
  logic [127:0] key_buf [0:14];
  logic         zeroize;

`ifdef AES_KEYSEQ_ZEROIZE_EN
  assign zeroize = zeroize_i;
`else
  assign zeroize = 1'b0;
`endif

  // The round index seen by the schedule stage is simply the counter; it
  // advances during CAPT while key_en_o is low so the stage never sees an
  // enabled request with a changing index.
  assign round_count_o = cnt;

  // Sequencer FSM. All handshake/status outputs are registered alongside the
  // state so they always describe the state being entered.
  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      key_en_o <= 1'b0;
      busy_o   <= 1'b0;
      ready_o  <= 1'b0;
    end else if (zeroize) begin
      // Zeroize wins over everything else in the same cycle.
      state    <= IDLE;
      cnt      <= 4'd0;
      key_en_o <= 1'b0;
      busy_o   <= 1'b0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state    <= REQ;
            cnt      <= 4'd0;
            key_en_o <= 1'b1;
            busy_o   <= 1'b1;
          end
        end

        REQ: begin
          // start_i is deliberately ignored while an expansion is running.
          if (key_done_i) begin
            state    <= CAPT;
            key_en_o <= 1'b0;
          end
        end

        CAPT: begin
          if (cnt == LAST_ROUND) begin
            state   <= READY;
            busy_o  <= 1'b0;
            ready_o <= 1'b1;
          end else begin
            state    <= REQ;
            cnt      <= cnt + 4'd1;
            key_en_o <= 1'b1;
          end
        end

        READY: begin
          // A concurrent read is still served from the old contents by the
          // read path, which looks at the current (READY) state.
          if (start_i) begin
            state    <= REQ;
            cnt      <= 4'd0;
            key_en_o <= 1'b1;
            busy_o   <= 1'b1;
            ready_o  <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          cnt      <= 4'd0;
          key_en_o <= 1'b0;
          busy_o   <= 1'b0;
          ready_o  <= 1'b0;
        end
      endcase
    end
  end

  // Round-key buffer. No reset: contents are unreachable until a complete
  // expansion has refilled every entry, so clearing them buys nothing.
  always_ff @(posedge clk_g) begin
    if (zeroize) begin
      for (int i = 0; i < 15; i++) begin
        key_buf[i] <= '0;
      end
    end else if (state == CAPT) begin
      key_buf[cnt] <= key_i;
    end
  end

  // Read port. Strobes and data are one-cycle registered responses; rk_o is
  // forced to zero whenever it does not carry a valid key so stale key
  // material never lingers on the bus.
  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      rk_o       <= '0;
      rk_valid_o <= 1'b0;
      rd_err_o   <= 1'b0;
    end else begin
      rk_o       <= '0;
      rk_valid_o <= 1'b0;
      rd_err_o   <= 1'b0;
      if (!zeroize && rd_en_i) begin
        if (state == READY && rd_round_i <= LAST_ROUND) begin
          rk_o       <= key_buf[rd_round_i];
          rk_valid_o <= 1'b1;
        end else begin
          rd_err_o <= 1'b1;
        end
      end
    end
  end

  // Structural invariants of the sequencer.
  cnt_in_range_a : assert property (@(posedge clk_g) disable iff (!rst_n)
    cnt <= LAST_ROUND);

  key_en_only_in_req_a : assert property (@(posedge clk_g) disable iff (!rst_n)
    key_en_o == (state == REQ));

  busy_matches_state_a : assert property (@(posedge clk_g) disable iff (!rst_n)
    busy_o == (state == REQ || state == CAPT));

  ready_matches_state_a : assert property (@(posedge clk_g) disable iff (!rst_n)
    ready_o == (state == READY));

  strobes_exclusive_a : assert property (@(posedge clk_g) disable iff (!rst_n)
    !(rk_valid_o && rd_err_o));

endmodule

// File: tb/tb_aes_key_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_key_sequencer
//
// Self-checking bench for aes_key_sequencer. A behavioural AES-256 key
// schedule (3-cycle done latency) answers the sequencer's requests; expected
// round keys come from the bench's own key expansion and from published
// constants. Define AES_KEYSEQ_ZEROIZE_EN to also exercise zeroize_i.
// ---------------------------------------------------------------------------
module tb_aes_key_sequencer;

  logic         clk_g;
  logic         rst_n;
  logic         start_i;
  logic         key_en_o;
  logic [3:0]   round_count_o;
  logic         key_done_i;
  logic [127:0] key_i;
  logic         busy_o;
  logic         ready_o;
  logic         rd_en_i;
  logic [3:0]   rd_round_i;
  logic [127:0] rk_o;
  logic         rk_valid_o;
  logic         rd_err_o;
`ifdef AES_KEYSEQ_ZEROIZE_EN
  logic         zeroize_i;
`endif

  int tests;
  int failures;

  logic         sched_on;
  logic         stray_done;
  logic [3:0]   sched_idx;
  logic [127:0] sched_rk [0:14];

  localparam logic [255:0] KEY_A  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] RK0_A  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK1_A  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] RK14_A = 128'h24fc79ccbf0979e9371ac23c6d68de36;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  aes_key_sequencer dut (
    .clk_g         (clk_g),
    .rst_n         (rst_n),
    .start_i       (start_i),
`ifdef AES_KEYSEQ_ZEROIZE_EN
    .zeroize_i     (zeroize_i),
`endif
    .key_en_o      (key_en_o),
    .round_count_o (round_count_o),
    .key_done_i    (key_done_i),
    .key_i         (key_i),
    .busy_o        (busy_o),
    .ready_o       (ready_o),
    .rd_en_i       (rd_en_i),
    .rd_round_i    (rd_round_i),
    .rk_o          (rk_o),
    .rk_valid_o    (rk_valid_o),
    .rd_err_o      (rd_err_o)
  );

  initial clk_g = 1'b0;
  always #5 clk_g = ~clk_g;

  function automatic logic [31:0] subWord(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  // Reference AES-256 key expansion into sched_rk[0..14].
  task automatic expandKey(input logic [255:0] key);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t    = subWord({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0};
      end else if (i % 8 == 4) begin
        t = subWord(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) sched_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Key-schedule stage model: done pulse 3 cycles after key_en_o is seen,
  // round key presented the cycle after the pulse.
  initial begin
    key_done_i = 1'b0;
    key_i      = '0;
    sched_idx  = 4'd0;
    forever begin
      @(negedge clk_g);
      key_done_i = stray_done;
      if (sched_on && key_en_o) begin
        sched_idx  = round_count_o;
        key_done_i = 1'b0;
        repeat (2) @(negedge clk_g);
        key_done_i = 1'b1;
        @(negedge clk_g);
        key_done_i = 1'b0;
        key_i      = sched_rk[sched_idx];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then land on the negedge where the response
  // to that cycle is visible.
  task automatic applyStimulus(input logic rd_en, input logic [3:0] rd_round, input logic start);
    @(posedge clk_g); #1;
    rd_en_i    = rd_en;
    rd_round_i = rd_round;
    start_i    = start;
    @(posedge clk_g); #1;
    rd_en_i    = 1'b0;
    rd_round_i = 4'd0;
    start_i    = 1'b0;
    @(negedge clk_g);
  endtask

  task automatic strayDone();
    @(posedge clk_g); #1 stray_done = 1'b1;
    @(posedge clk_g); #1 stray_done = 1'b0;
    @(negedge clk_g);
  endtask

  task automatic waitReady(output int busy_cnt, output int en_cnt, output int over_cnt);
    bit done;
    busy_cnt = 0; en_cnt = 0; over_cnt = 0; done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      if (ready_o === 1'b1) begin
        done = 1'b1;
      end else begin
        if (busy_o) busy_cnt++;
        if (key_en_o) en_cnt++;
        if (round_count_o > 4'd14) over_cnt++;
        @(negedge clk_g);
      end
    end
    checkOutput("ready_reached", {127'd0, done}, 128'd1);
  endtask

  typedef struct {
    logic         rd_en;
    logic [3:0]   rd_round;
    logic         exp_valid;
    logic         exp_err;
    logic [127:0] exp_rk;
  } rd_vec_t;

  rd_vec_t vecs [0:16];

  initial begin
    int busy_cnt, en_cnt, over_cnt;
    bit found;
    tests = 0; failures = 0;
    rst_n = 1'b0; start_i = 1'b0; rd_en_i = 1'b0; rd_round_i = 4'd0;
    stray_done = 1'b0; sched_on = 1'b0;
`ifdef AES_KEYSEQ_ZEROIZE_EN
    zeroize_i = 1'b0;
`endif
    repeat (3) @(negedge clk_g);
    checkOutput("rst_key_en", {127'd0, key_en_o}, 128'd0);
    checkOutput("rst_busy", {127'd0, busy_o}, 128'd0);
    checkOutput("rst_ready", {127'd0, ready_o}, 128'd0);
    checkOutput("rst_round", {124'd0, round_count_o}, 128'd0);
    checkOutput("rst_rk", rk_o, 128'd0);
    checkOutput("rst_valid", {127'd0, rk_valid_o}, 128'd0);
    checkOutput("rst_err", {127'd0, rd_err_o}, 128'd0);
    @(posedge clk_g); #1 rst_n = 1'b1;

    // Read outside READY and a stray done pulse in IDLE.
    applyStimulus(1'b1, 4'd0, 1'b0);
    checkOutput("idle_rd_err", {127'd0, rd_err_o}, 128'd1);
    checkOutput("idle_rd_valid", {127'd0, rk_valid_o}, 128'd0);
    strayDone();
    checkOutput("idle_stray_busy", {127'd0, busy_o}, 128'd0);
    checkOutput("idle_stray_en", {127'd0, key_en_o}, 128'd0);

    // Full expansion with the FIPS-197 AES-256 key.
    expandKey(KEY_A);
    sched_on = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b1);
    checkOutput("start_key_en", {127'd0, key_en_o}, 128'd1);
    checkOutput("start_busy", {127'd0, busy_o}, 128'd1);
    checkOutput("start_round", {124'd0, round_count_o}, 128'd0);
    waitReady(busy_cnt, en_cnt, over_cnt);
    checkOutput("busy_cycles", busy_cnt, 128'd60);
    checkOutput("req_cycles", en_cnt, 128'd45);
    checkOutput("cnt_overflow", over_cnt, 128'd0);
    checkOutput("ready_busy", {127'd0, busy_o}, 128'd0);
    checkOutput("ready_key_en", {127'd0, key_en_o}, 128'd0);
    checkOutput("ready_round", {124'd0, round_count_o}, 128'd14);

    // Read table: every round, the illegal index, and an idle cycle.
    for (int r = 0; r < 15; r++) vecs[r] = '{1'b1, 4'(r), 1'b1, 1'b0, sched_rk[r]};
    vecs[0].exp_rk  = RK0_A;
    vecs[1].exp_rk  = RK1_A;
    vecs[14].exp_rk = RK14_A;
    vecs[15] = '{1'b1, 4'd15, 1'b0, 1'b1, 128'd0};
    vecs[16] = '{1'b0, 4'd3, 1'b0, 1'b0, 128'd0};
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].rd_en, vecs[i].rd_round, 1'b0);
      checkOutput($sformatf("vec%0d_rk", i), rk_o, vecs[i].exp_rk);
      checkOutput($sformatf("vec%0d_valid", i), {127'd0, rk_valid_o}, {127'd0, vecs[i].exp_valid});
      checkOutput($sformatf("vec%0d_err", i), {127'd0, rd_err_o}, {127'd0, vecs[i].exp_err});
    end

    // Stray done in READY leaves the buffer and state alone.
    strayDone();
    checkOutput("ready_stray_ready", {127'd0, ready_o}, 128'd1);
    checkOutput("ready_stray_busy", {127'd0, busy_o}, 128'd0);
    applyStimulus(1'b1, 4'd1, 1'b0);
    checkOutput("ready_stray_rk1", rk_o, RK1_A);

    // Start with a concurrent read: old key returned, new expansion begins.
    applyStimulus(1'b1, 4'd14, 1'b1);
    checkOutput("rdstart_rk", rk_o, RK14_A);
    checkOutput("rdstart_valid", {127'd0, rk_valid_o}, 128'd1);
    checkOutput("rdstart_ready", {127'd0, ready_o}, 128'd0);
    checkOutput("rdstart_round", {124'd0, round_count_o}, 128'd0);
    checkOutput("rdstart_busy", {127'd0, busy_o}, 128'd1);

    // Read and start during REQ of round 5: error strobe, start ignored.
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (round_count_o == 4'd5 && key_en_o) found = 1'b1;
      else @(negedge clk_g);
    end
    checkOutput("reach_round5", {127'd0, found}, 128'd1);
    applyStimulus(1'b1, 4'd0, 1'b1);
    checkOutput("req_start_round", {124'd0, round_count_o}, 128'd5);
    checkOutput("req_rd_err", {127'd0, rd_err_o}, 128'd1);
    checkOutput("req_rd_valid", {127'd0, rk_valid_o}, 128'd0);
    checkOutput("req_rd_rk", rk_o, 128'd0);
    waitReady(busy_cnt, en_cnt, over_cnt);
    applyStimulus(1'b1, 4'd14, 1'b0);
    checkOutput("rerun_rk14", rk_o, RK14_A);

    // Reset in the CAPT cycle of round 7, then a clean restart.
    applyStimulus(1'b0, 4'd0, 1'b1);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (busy_o && !key_en_o && round_count_o == 4'd7) found = 1'b1;
      else @(negedge clk_g);
    end
    checkOutput("reach_capt7", {127'd0, found}, 128'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", {127'd0, busy_o}, 128'd0);
    checkOutput("midrst_round", {124'd0, round_count_o}, 128'd0);
    checkOutput("midrst_key_en", {127'd0, key_en_o}, 128'd0);
    checkOutput("midrst_ready", {127'd0, ready_o}, 128'd0);
    @(posedge clk_g); #1 rst_n = 1'b1;
    @(negedge clk_g);
    checkOutput("postrst_busy", {127'd0, busy_o}, 128'd0);
    applyStimulus(1'b0, 4'd0, 1'b1);
    checkOutput("restart_round", {124'd0, round_count_o}, 128'd0);
    checkOutput("restart_key_en", {127'd0, key_en_o}, 128'd1);
    waitReady(busy_cnt, en_cnt, over_cnt);
    checkOutput("restart_busy_cycles", busy_cnt, 128'd60);
    applyStimulus(1'b1, 4'd0, 1'b0);
    checkOutput("restart_rk0", rk_o, RK0_A);
    applyStimulus(1'b1, 4'd7, 1'b0);
    checkOutput("restart_rk7", rk_o, sched_rk[7]);
    applyStimulus(1'b1, 4'd14, 1'b0);
    checkOutput("restart_rk14", rk_o, RK14_A);

`ifdef AES_KEYSEQ_ZEROIZE_EN
    // Zeroize overrides a simultaneous start and read.
    @(posedge clk_g); #1;
    zeroize_i = 1'b1; start_i = 1'b1; rd_en_i = 1'b1; rd_round_i = 4'd0;
    @(posedge clk_g); #1;
    zeroize_i = 1'b0; start_i = 1'b0; rd_en_i = 1'b0;
    @(negedge clk_g);
    checkOutput("zero_ready", {127'd0, ready_o}, 128'd0);
    checkOutput("zero_busy", {127'd0, busy_o}, 128'd0);
    checkOutput("zero_round", {124'd0, round_count_o}, 128'd0);
    checkOutput("zero_valid", {127'd0, rk_valid_o}, 128'd0);
    checkOutput("zero_err", {127'd0, rd_err_o}, 128'd0);
    expandKey(256'd0);
    applyStimulus(1'b0, 4'd0, 1'b1);
    waitReady(busy_cnt, en_cnt, over_cnt);
    applyStimulus(1'b1, 4'd0, 1'b0);
    checkOutput("zero_key_rk0", rk_o, 128'd0);
    checkOutput("zero_key_valid", {127'd0, rk_valid_o}, 128'd1);
    applyStimulus(1'b1, 4'd14, 1'b0);
    checkOutput("zero_key_rk14", rk_o, sched_rk[14]);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/aes_key_sequencer.md
AES_KEY_SEQUENCER -- requirements
Module: aes_key_sequencer

Interface
REQ-001 SHALL have port clk_g  input  1  gated core clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port start_i  input  1  request a full AES-256 key expansion.
REQ-004 SHALL have port key_en_o  output  1  enable to key-schedule stage.
REQ-005 SHALL have port round_count_o  output  4  round index presented to key-schedule stage.
REQ-006 SHALL have port key_done_i  input  1  one-cycle done pulse from key-schedule stage.
REQ-007 SHALL have port key_i  input  128  round key from key-schedule stage; valid the cycle after key_done_i.
REQ-008 SHALL have port busy_o  output  1  expansion in progress.
REQ-009 SHALL have port ready_o  output  1  all 15 round keys stored.
REQ-010 SHALL have ports rd_en_i input 1 and rd_round_i input 4: round-key read request and index.
REQ-011 SHALL have ports rk_o output 128, rk_valid_o output 1, rd_err_o output 1: read data, valid strobe, error strobe.

Function
REQ-012 SHALL hold a 15 x 128-bit round-key buffer and a 4-bit round counter cnt.
REQ-013 SHALL implement FSM states IDLE, REQ, CAPT, READY.
REQ-014 IDLE: busy_o=0, ready_o=0, key_en_o=0; start_i -> cnt=0, go REQ.
REQ-015 REQ: key_en_o=1, busy_o=1, round_count_o=cnt; stay until key_done_i=1, then go CAPT.
REQ-016 CAPT: key_en_o=0, busy_o=1; write key_i to buffer[cnt]; cnt==14 -> READY, else cnt+1 -> REQ.
REQ-017 key_en_o SHALL be 0 in CAPT so the schedule stage idles while round_count_o advances.
REQ-018 round_count_o SHALL equal cnt in all states; cnt SHALL never exceed 14.
REQ-019 READY: ready_o=1, busy_o=0; start_i -> cnt=0, ready_o=0 next cycle, go REQ; buffer contents retained until overwritten.
REQ-020 start_i in REQ or CAPT SHALL be ignored.
REQ-021 Read: rd_en_i=1 in READY with rd_round_i<=14 -> next cycle rk_o=buffer[rd_round_i], rk_valid_o=1 for one cycle.
REQ-022 Read with rd_round_i=15, or rd_en_i outside READY -> next cycle rd_err_o=1 for one cycle, rk_valid_o=0, rk_o=0.
REQ-023 rd_en_i and start_i together in READY: read serviced from old contents; FSM goes REQ.
REQ-024 key_done_i in IDLE, CAPT or READY SHALL be ignored.
REQ-025 Full expansion SHALL take exactly 15 REQ->CAPT passes; total latency = 15 + sum of REQ wait cycles.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, cnt=0, key_en_o=0, busy_o=0, ready_o=0, rk_o=0, rk_valid_o=0, rd_err_o=0.
REQ-027 Buffer contents SHALL be don't-care after reset; unreachable until next completed expansion.
REQ-028 Reset mid-expansion SHALL abandon the expansion; next start_i restarts from round 0.

Configuration
REQ-029 Macro AES_KEYSEQ_ZEROIZE_EN defined: add input zeroize_i (1 bit); zeroize_i=1 clears all 15 entries to 0 in one cycle, forces IDLE, cnt=0, ready_o=0; overrides start_i and rd_en_i same cycle.
REQ-030 Macro undefined: no zeroize_i port; buffer changes only via CAPT writes.

Verification
REQ-031 Key 000102..1f, schedule model with 3-cycle done latency -> ready_o=1 after 15 passes; rd_round_i=0 -> rk_o=000102030405060708090a0b0c0d0e0f.
REQ-032 Same key, rd_round_i=1 -> 101112131415161718191a1b1c1d1e1f; rd_round_i=14 -> 24fc79ccbf0979e9371ac23c6d68de36.
REQ-033 rd_en_i with rd_round_i=15 in READY, and rd_en_i in REQ -> rd_err_o=1 one cycle, rk_valid_o=0, rk_o=0.
REQ-034 rst_n low during CAPT of cnt=7 -> all outputs reset; new start_i -> round_count_o=0, full expansion completes correctly.
REQ-035 start_i in READY with concurrent rd_round_i=14 -> old round-14 key returned; ready_o=0 next cycle; round_count_o=0.
REQ-036 AES_KEYSEQ_ZEROIZE_EN defined: zeroize_i in READY -> IDLE, ready_o=0; after re-expansion with key all-zero, rd_round_i=0 -> 0.
